step_sequencer: RTL and testbench

Command-driven step/dir pulse scheduler that drives the step, dir and enable inputs of the dual H-bridge microstep driver.
- Accepts move commands (direction, step count, step period) over a valid/ready handshake.
- Emits step pulses with guaranteed minimum high/low widths and dir setup time before the first pulse.
- Manages the bridge enable and reports progress and completion to the host register layer.

---
 rtl/step_seq_pkg.sv | 15 +
 rtl/step_timer.sv | 30 +++
 rtl/step_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_step_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/step_seq_pkg.sv
// Shared definitions for the step/dir pulse sequencer: FSM state encoding
// and the minimum step high time the bridge edge detector can resolve.
package step_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    HIGH   = 3'd2,
    LOW    = 3'd3,
    FINISH = 3'd4
  } seq_state_e;

  localparam int unsigned MIN_PULSE_WIDTH = 2;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter shared by the SETUP, HIGH and LOW phases.
// The count parks at zero and zero_flag marks the last cycle of a phase.
module step_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero_flag
);

  logic [WIDTH-1:0] cnt_r;

  // Phase countdown: load wins, otherwise decrement until zero and hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (load) begin
      cnt_r <= load_value;
    end else if (cnt_r != {WIDTH{1'b0}}) begin
      cnt_r <= cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero_flag = (cnt_r == {WIDTH{1'b0}});

endmodule

// File: rtl/step_sequencer.sv
// Command-driven step/dir/enable scheduler for the H-bridge microstep driver.
// Optional bridge idle power-down is built when STEP_SEQ_IDLE_OFF_EN is defined.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int unsigned COUNT_BITS  = 32,
  parameter int unsigned PERIOD_BITS = 32,
  parameter int unsigned PULSE_WIDTH = 4,
  parameter int unsigned DIR_SETUP   = 16,
  parameter int unsigned IDLE_BITS   = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_dir,
  input  logic [COUNT_BITS-1:0]  cmd_steps,
  input  logic [PERIOD_BITS-1:0] cmd_period,
  input  logic                   abort,
  output logic                   step,
  output logic                   dir,
  output logic                   enable,
  output logic                   busy,
  output logic [COUNT_BITS-1:0]  steps_remaining,
  output logic                   done,
  output logic                   aborted
`ifdef STEP_SEQ_IDLE_OFF_EN
  ,
  input  logic [IDLE_BITS-1:0]   idle_timeout
`endif
);

  // An out-of-range pulse width is clamped so the bridge still sees the edge
  localparam int unsigned HIGH_CYCLES = (PULSE_WIDTH < MIN_PULSE_WIDTH) ? MIN_PULSE_WIDTH : PULSE_WIDTH;
  localparam logic [PERIOD_BITS-1:0] MIN_PERIOD = PERIOD_BITS'(2 * HIGH_CYCLES);
  localparam logic [PERIOD_BITS-1:0] HIGH_LOAD  = PERIOD_BITS'(HIGH_CYCLES - 1);
  localparam logic [PERIOD_BITS-1:0] SETUP_LOAD = PERIOD_BITS'(DIR_SETUP - 1);
  localparam logic [PERIOD_BITS-1:0] LOW_ADJ    = PERIOD_BITS'(HIGH_CYCLES + 1);
  localparam logic [COUNT_BITS-1:0]  ZERO_STEPS = {COUNT_BITS{1'b0}};
  localparam logic [COUNT_BITS-1:0]  ONE_STEP   = {{(COUNT_BITS-1){1'b0}}, 1'b1};

  seq_state_e              state_r, state_nxt_s;
  logic                    accept_s, setup_need_s, rise_s, abort_end_s, idle_hit_s;
  logic                    tmr_load_s, tmr_zero_s;
  logic [PERIOD_BITS-1:0]  tmr_val_s, eff_s, low_load_r;
  logic                    abort_pend_r, step_r, dir_r, enable_r, busy_r, done_r, aborted_r;
  logic [COUNT_BITS-1:0]   rem_r;

  assign cmd_ready    = (state_r == IDLE) && !abort;
  assign accept_s     = cmd_valid && cmd_ready;
  assign setup_need_s = !enable_r || (cmd_dir != dir_r);
  assign eff_s        = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
  assign rise_s       = (state_nxt_s == HIGH) && (state_r != HIGH);

  step_timer #(.WIDTH(PERIOD_BITS)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load_s),
    .load_value (tmr_val_s),
    .zero_flag  (tmr_zero_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and phase timer loads
  always_comb begin
    state_nxt_s = state_r;
    tmr_load_s  = 1'b0;
    tmr_val_s   = HIGH_LOAD;
    abort_end_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (cmd_steps == ZERO_STEPS) begin
            state_nxt_s = FINISH;
          end else if (setup_need_s) begin
            state_nxt_s = SETUP;
            tmr_load_s  = 1'b1;
            tmr_val_s   = SETUP_LOAD;
          end else begin
            state_nxt_s = HIGH;
            tmr_load_s  = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: begin
        if (abort) begin
          state_nxt_s = FINISH;
          abort_end_s = 1'b1;
        end else if (tmr_zero_s) begin
          state_nxt_s = HIGH;
          tmr_load_s  = 1'b1;
        end else begin
          state_nxt_s = SETUP;
        end
      end
      HIGH: begin
        // An abort seen mid-pulse only takes effect once the pulse is complete
        if (tmr_zero_s) begin
          if (abort || abort_pend_r) begin
            state_nxt_s = FINISH;
            abort_end_s = 1'b1;
          end else begin
            state_nxt_s = LOW;
            tmr_load_s  = 1'b1;
            tmr_val_s   = low_load_r;
          end
        end else begin
          state_nxt_s = HIGH;
        end
      end
      LOW: begin
        if (abort) begin
          state_nxt_s = FINISH;
          abort_end_s = 1'b1;
        end else if (tmr_zero_s) begin
          if (rem_r != ZERO_STEPS) begin
            state_nxt_s = HIGH;
            tmr_load_s  = 1'b1;
          end else begin
            state_nxt_s = FINISH;
          end
        end else begin
          state_nxt_s = LOW;
        end
      end
      FINISH: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Registered bridge/status outputs and per-move latches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
      abort_pend_r <= 1'b0;
      low_load_r   <= {PERIOD_BITS{1'b0}};
    end else begin
      step_r       <= (state_nxt_s == HIGH);
      busy_r       <= (state_nxt_s != IDLE);
      done_r       <= (state_nxt_s == FINISH);
      aborted_r    <= (state_nxt_s == FINISH) && abort_end_s;
      abort_pend_r <= (state_r == HIGH) && (state_nxt_s == HIGH) && (abort || abort_pend_r);
      low_load_r   <= accept_s ? (eff_s - LOW_ADJ) : low_load_r;
    end
  end

  // Remaining pulse count, decremented on each rising step edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_r <= ZERO_STEPS;
    end else if (accept_s) begin
      rem_r <= (state_nxt_s == HIGH) ? (cmd_steps - ONE_STEP) : cmd_steps;
    end else if (rise_s) begin
      rem_r <= rem_r - ONE_STEP;
    end else begin
      rem_r <= rem_r;
    end
  end

  // Direction and bridge enable, changed only by a non-empty move or power-down
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_r    <= 1'b0;
      enable_r <= 1'b0;
    end else if (accept_s && (cmd_steps != ZERO_STEPS)) begin
      dir_r    <= cmd_dir;
      enable_r <= 1'b1;
    end else if (idle_hit_s) begin
      dir_r    <= dir_r;
      enable_r <= 1'b0;
    end else begin
      dir_r    <= dir_r;
      enable_r <= enable_r;
    end
  end

`ifdef STEP_SEQ_IDLE_OFF_EN
  logic [IDLE_BITS-1:0] idle_cnt_r;
  logic                 idle_arm_s;

  assign idle_arm_s = (state_r == IDLE) && enable_r && (idle_timeout != {IDLE_BITS{1'b0}});
  assign idle_hit_s = idle_arm_s &&
                      (({1'b0, idle_cnt_r} + {{IDLE_BITS{1'b0}}, 1'b1}) >= {1'b0, idle_timeout});

  // Idle cycle counter for bridge power-down
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_r <= {IDLE_BITS{1'b0}};
    end else if (accept_s || idle_hit_s) begin
      idle_cnt_r <= {IDLE_BITS{1'b0}};
    end else if (idle_arm_s) begin
      idle_cnt_r <= idle_cnt_r + {{(IDLE_BITS-1){1'b0}}, 1'b1};
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end
`else
  assign idle_hit_s = 1'b0;
`endif

  assign step            = step_r;
  assign dir             = dir_r;
  assign enable          = enable_r;
  assign busy            = busy_r;
  assign steps_remaining = rem_r;
  assign done            = done_r;
  assign aborted         = aborted_r;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: directed scenarios plus random moves
// compared cycle by cycle against a closed-form timing model of each move.
module tb_step_sequencer;

  localparam int CB = 32;
  localparam int PB = 32;
  localparam int PW = 4;
  localparam int DS = 16;

  logic          clk = 1'b0;
  logic          reset, cmd_valid, cmd_ready, cmd_dir, abort;
  logic          step, dir, enable, busy, done, aborted;
  logic [CB-1:0] cmd_steps, steps_remaining;
  logic [PB-1:0] cmd_period;

  int n_cmp = 0;
  int n_bad = 0;
  bit m_dir = 1'b0;
  bit m_en  = 1'b0;

  step_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_dir         (cmd_dir),
    .cmd_steps       (cmd_steps),
    .cmd_period      (cmd_period),
    .abort           (abort),
    .step            (step),
    .dir             (dir),
    .enable          (enable),
    .busy            (busy),
    .steps_remaining (steps_remaining),
    .done            (done),
    .aborted         (aborted)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_dir = 1'b0; cmd_steps = '0; cmd_period = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({step, dir, enable, busy, done, aborted} !== 6'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 000000", {step, dir, enable, busy, done, aborted});
    end
    n_cmp++; if (steps_remaining !== 32'd0) begin
      n_bad++; $display("FAIL reset_remaining: got %0d want 0", steps_remaining);
    end
    n_cmp++; if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
    reset = 1'b0;
    m_dir = 1'b0; m_en = 1'b0;
    @(posedge clk); #1;
  endtask

  // One move accepted in cycle 0; a>=1 pulses abort for one cycle at that index
  task automatic run_move(input bit d, input logic [CB-1:0] n, input logic [PB-1:0] p, input int a);
    longint eff, first, ndone, done_c, issued, k, off, rel, rises;
    bit setup, ab, exp_step;
    logic [CB-1:0] exp_rem;
    eff    = (longint'(p) < 2 * PW) ? 2 * PW : longint'(p);
    setup  = (n != 0) && (!m_en || d != m_dir);
    first  = setup ? DS + 1 : 1;
    ndone  = (n == 0) ? 1 : first + longint'(n) * eff;
    ab     = (n != 0) && (a >= 1) && (a < ndone);
    done_c = ndone;
    issued = longint'(n);
    if (ab && a < first) begin
      done_c = a + 1; issued = 0;
    end else if (ab) begin
      k = (a - first) / eff; off = (a - first) % eff;
      issued = k + 1;
      done_c = (off < PW) ? first + k * eff + PW : a + 1;
    end
    cmd_valid = 1'b1; cmd_dir = d; cmd_steps = n; cmd_period = p; abort = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL accept_ready: got %b want 1", cmd_ready);
    end
    n_cmp++; if (busy !== 1'b0) begin
      n_bad++; $display("FAIL accept_busy: got %b want 0", busy);
    end
    if (n != 0) begin m_dir = d; m_en = 1'b1; end
    for (longint c = 1; c <= done_c; c++) begin
      @(posedge clk); #1;
      cmd_valid  = 1'b0;
      cmd_dir    = 1'($urandom_range(0, 1));
      cmd_steps  = $urandom();
      cmd_period = $urandom();
      abort      = (c == longint'(a));
      @(negedge clk);
      rel      = c - first;
      rises    = (c < first) ? 0 : rel / eff + 1;
      if (rises > issued) rises = issued;
      exp_step = (c >= first) && (rel / eff < issued) && (rel % eff < PW);
      exp_rem  = n - CB'(rises);
      n_cmp++; if (step !== exp_step) begin
        n_bad++; $display("FAIL step c=%0d: got %b want %b", c, step, exp_step);
      end
      n_cmp++; if (steps_remaining !== exp_rem) begin
        n_bad++; $display("FAIL remaining c=%0d: got %0d want %0d", c, steps_remaining, exp_rem);
      end
      n_cmp++; if ({dir, enable, busy} !== {m_dir, m_en, 1'b1}) begin
        n_bad++; $display("FAIL dir_en_busy c=%0d: got %b want %b", c, {dir, enable, busy}, {m_dir, m_en, 1'b1});
      end
      n_cmp++; if ({done, aborted} !== {c == done_c, (c == done_c) && ab}) begin
        n_bad++; $display("FAIL done_aborted c=%0d: got %b want %b", c, {done, aborted}, {c == done_c, (c == done_c) && ab});
      end
    end
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_cmp++; if ({busy, step, done} !== 3'b000) begin
        n_bad++; $display("FAIL idle_gap: got %b want 000", {busy, step, done});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort_idle();
    abort = 1'b1; cmd_valid = 1'b1; cmd_dir = ~m_dir; cmd_steps = 32'd5; cmd_period = 32'd10;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle_ready: got %b want 0", cmd_ready);
    end
    @(posedge clk); #1;
    abort = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, dir, cmd_ready} !== {1'b0, m_dir, 1'b1}) begin
      n_bad++; $display("FAIL abort_idle_noaccept: got %b want %b", {busy, dir, cmd_ready}, {1'b0, m_dir, 1'b1});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    cmd_valid = 1'b1; cmd_dir = ~m_dir; cmd_steps = 32'd3; cmd_period = 32'd20; abort = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    n_cmp++; if ({busy, enable, step} !== 3'b110) begin
      n_bad++; $display("FAIL pre_reset_low: got %b want 110", {busy, enable, step});
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({step, enable, busy, dir, done} !== 5'b0 || steps_remaining !== 32'd0) begin
      n_bad++; $display("FAIL async_reset: got %b/%0d want 00000/0", {step, enable, busy, dir, done}, steps_remaining);
    end
    @(negedge clk); reset = 1'b0;
    m_dir = 1'b0; m_en = 1'b0;
    @(posedge clk); #1;
    run_move(1'b1, 32'd1, 32'd8, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 15; i++) begin
      wait_idle(int'($urandom_range(0, 2)));
      run_move(1'($urandom_range(0, 1)), 32'($urandom_range(0, 5)), 32'($urandom_range(0, 30)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 80)) : -1);
    end
  endtask

  initial begin
    test_reset();
    run_move(1'b1, 32'd3, 32'd20, -1);      // setup move
    run_move(1'b1, 32'd2, 32'd3, -1);       // same dir, clamped period
    run_move(1'b0, 32'd2, 32'd10, -1);      // direction change
    run_move(1'b1, 32'd0, 32'd50, -1);      // empty move
    run_move(1'b0, 32'd1, 32'd8, -1);       // back-to-back after empty move
    run_move(1'b0, 32'd10, 32'd20, 23);     // abort 2 cycles into second high
    run_move(1'b1, 32'd4, 32'd12, 9);       // abort during setup
    run_move(1'b1, 32'd4, 32'd12, 7);       // abort during low
    test_abort_idle();
    run_move(m_dir, 32'hFFFF_FFFF, 32'd9, 40);
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
